bp_cce_pc: RTL and testbench

CCE instruction fetch stage: owns the microcode program counter and the synchronous instruction RAM, and presents one instruction per cycle to decode. It sits directly downstream of `bp_cce_alu`, consuming its `branch_res_o` to redirect fetch. It also accepts the microcode image over a simple write port while the CCE is idle.

---
 rtl/bp_cce_pc_if.sv | 30 +++
 rtl/bp_cce_pc.sv | 91 +++++++++
 tb/tb_bp_cce_pc.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bp_cce_pc_if.sv
// Fetch-stage bus: microcode image load port, start/stall/branch controls
// and the instruction stream presented to decode.
interface bp_cce_pc_if #(
    parameter int inst_ram_addr_width_p = 8,
    parameter int inst_width_p          = 32
);
    logic                             cfg_w_v_i;
    logic [inst_ram_addr_width_p-1:0] cfg_addr_i;
    logic [inst_width_p-1:0]          cfg_data_i;
    logic                             cfg_ready_o;
    logic                             start_i;
    logic                             stall_i;
    logic                             branch_res_i;
    logic [inst_ram_addr_width_p-1:0] branch_target_i;
    logic                             inst_v_o;
    logic [inst_width_p-1:0]          inst_o;
    logic [inst_ram_addr_width_p-1:0] pc_o;

    modport master (
        output cfg_w_v_i, cfg_addr_i, cfg_data_i, start_i, stall_i,
               branch_res_i, branch_target_i,
        input  cfg_ready_o, inst_v_o, inst_o, pc_o
    );

    modport slave (
        input  cfg_w_v_i, cfg_addr_i, cfg_data_i, start_i, stall_i,
               branch_res_i, branch_target_i,
        output cfg_ready_o, inst_v_o, inst_o, pc_o
    );
endinterface

// File: rtl/bp_cce_pc.sv
// CCE microcode fetch: program counter, synchronous instruction RAM, and
// redirect on taken branches resolved by the ALU (static not-taken prediction).
module bp_cce_pc #(
    parameter int inst_ram_addr_width_p = 8,
    parameter int inst_width_p          = 32,
    parameter int boot_pc_p             = 0
) (
    input  logic           clk_i,
    input  logic           reset_i,
    bp_cce_pc_if.slave     io
);
    localparam int                             DEPTH   = 1 << inst_ram_addr_width_p;
    localparam logic [inst_ram_addr_width_p-1:0] BOOT_PC = inst_ram_addr_width_p'(boot_pc_p);
    localparam logic [inst_ram_addr_width_p-1:0] PC_ONE  = inst_ram_addr_width_p'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                           state_reg;
    logic [inst_ram_addr_width_p-1:0] fetch_pc_reg;
    logic [inst_ram_addr_width_p-1:0] pc_reg;
    logic                             inst_v_reg;
    logic                             cfg_ready_reg;
    logic [inst_width_p-1:0]          inst_reg;

    logic [inst_width_p-1:0] mem [DEPTH];

    logic stall;
    logic squash;
    logic ram_we;
    logic ram_re;

    // A stall or branch only means something while a valid instruction is shown.
    assign stall  = io.stall_i & inst_v_reg;
    assign squash = io.branch_res_i & inst_v_reg;
    assign ram_we = (state_reg == IDLE) & io.cfg_w_v_i;
    assign ram_re = (state_reg == RUN) & ~stall;

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem[io.cfg_addr_i] <= io.cfg_data_i;
        end
    end

    // Registered read port; holds its value whenever no read is issued.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inst_reg <= '0;
        end else if (ram_re) begin
            inst_reg <= mem[fetch_pc_reg];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= BOOT_PC;
            pc_reg        <= '0;
            inst_v_reg    <= 1'b0;
            cfg_ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io.start_i) begin
                        state_reg     <= RUN;
                        cfg_ready_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        pc_reg     <= fetch_pc_reg;
                        inst_v_reg <= ~squash;
                        if (squash) begin
                            fetch_pc_reg <= io.branch_target_i;
                        end else begin
                            fetch_pc_reg <= fetch_pc_reg + PC_ONE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io.cfg_ready_o = cfg_ready_reg;
    assign io.inst_v_o    = inst_v_reg;
    assign io.inst_o      = inst_reg;
    assign io.pc_o        = pc_reg;
endmodule

// File: tb/tb_bp_cce_pc.sv
// Bench for bp_cce_pc: directed image load / branch / stall / reset steps and
// a random run, checked against a delivered-instruction-stream model.
module tb_bp_cce_pc;
    localparam int AW = 3;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_cce_pc_if #(.inst_ram_addr_width_p(AW), .inst_width_p(IW)) ifa ();
    bp_cce_pc_if #(.inst_ram_addr_width_p(AW), .inst_width_p(IW)) ifb ();

    bp_cce_pc #(.inst_ram_addr_width_p(AW), .inst_width_p(IW), .boot_pc_p(0)) dut_a (
        .clk_i(clk), .reset_i(reset), .io(ifa.slave)
    );
    bp_cce_pc #(.inst_ram_addr_width_p(AW), .inst_width_p(IW), .boot_pc_p(6)) dut_b (
        .clk_i(clk), .reset_i(reset), .io(ifb.slave)
    );

    int tests = 0;
    int fails = 0;

    // Model: image contents plus the next instruction decode should receive.
    logic [IW-1:0] mem_m [8];
    logic [AW-1:0] exp_pc;
    logic          exp_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One RUN cycle: check what is shown, drive this cycle's controls, advance model.
    task automatic cyc(input logic st, input logic br, input logic [AW-1:0] tg);
        @(negedge clk);
        chk("inst_v", 32'(ifa.inst_v_o), 32'(exp_v));
        if (exp_v) begin
            chk("pc", 32'(ifa.pc_o), 32'(exp_pc));
            chk("inst", 32'(ifa.inst_o), 32'(mem_m[exp_pc]));
        end
        chk("cfg_ready_run", 32'(ifa.cfg_ready_o), 32'd0);
        ifa.cfg_w_v_i = 1'b0; ifa.start_i = 1'b0; ifb.cfg_w_v_i = 1'b0;
        ifa.stall_i = st; ifa.branch_res_i = br; ifa.branch_target_i = tg;
        if (!exp_v) begin
            exp_v = 1'b1;
        end else if (!st) begin
            if (br) begin
                exp_pc = tg;
                exp_v  = 1'b0;
            end else begin
                exp_pc = exp_pc + 3'd1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifa.cfg_w_v_i = 1'b0; ifa.start_i = 1'b0; ifa.stall_i = 1'b0; ifa.branch_res_i = 1'b0;
        ifb.cfg_w_v_i = 1'b0; ifb.start_i = 1'b0;
        @(negedge clk);
        chk("rst_inst_v", 32'(ifa.inst_v_o), 32'd0);
        chk("rst_inst", 32'(ifa.inst_o), 32'd0);
        chk("rst_pc", 32'(ifa.pc_o), 32'd0);
        chk("rst_cfg_ready", 32'(ifa.cfg_ready_o), 32'd1);
        reset = 1'b0;
        exp_v = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic st);
        @(negedge clk);
        chk("idle_cfg_ready", 32'(ifa.cfg_ready_o), 32'd1);
        chk("idle_inst_v", 32'(ifa.inst_v_o), 32'd0);
        ifa.cfg_w_v_i = 1'b1; ifa.cfg_addr_i = a; ifa.cfg_data_i = d; ifa.start_i = st;
        ifb.cfg_w_v_i = 1'b1; ifb.cfg_addr_i = a; ifb.cfg_data_i = d;
        mem_m[a] = d;
        if (st) begin
            exp_v  = 1'b0;
            exp_pc = 3'd0;
        end
    endtask

    initial begin
        logic [AW-1:0] p;
        reset = 1'b1;
        ifa.cfg_w_v_i = 1'b0; ifa.cfg_addr_i = '0; ifa.cfg_data_i = '0; ifa.start_i = 1'b0;
        ifa.stall_i = 1'b0; ifa.branch_res_i = 1'b0; ifa.branch_target_i = '0;
        ifb.cfg_w_v_i = 1'b0; ifb.cfg_addr_i = '0; ifb.cfg_data_i = '0; ifb.start_i = 1'b0;
        ifb.stall_i = 1'b0; ifb.branch_res_i = 1'b0; ifb.branch_target_i = '0;
        @(negedge clk);
        do_reset();

        // Image load; last write shares its cycle with start.
        for (int i = 0; i < 8; i++) load(3'(i), 8'(8'h10 + i), i == 7);
        repeat (9) cyc(1'b0, 1'b0, 3'd0);

        // Taken branch at PC 2 to 6.
        do_reset();
        load(3'd0, 8'h10, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd6);
        repeat (3) cyc(1'b0, 1'b0, 3'd0);

        // Stall three cycles at PC 4 with a branch that must be ignored.
        do_reset();
        load(3'd0, 8'h10, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 3'd0);
        repeat (3) cyc(1'b1, 1'b1, 3'd1);
        repeat (2) cyc(1'b0, 1'b0, 3'd0);

        // Write attempt during RUN must not reach the RAM.
        ifa.cfg_w_v_i = 1'b1; ifa.cfg_addr_i = 3'd1; ifa.cfg_data_i = 8'hAA;
        cyc(1'b0, 1'b0, 3'd0);

        // Reset while PC 5 is shown, then restart from the retained image.
        do_reset();
        load(3'd0, 8'h10, 1'b1);
        repeat (7) cyc(1'b0, 1'b0, 3'd0);
        do_reset();
        load(3'd0, 8'h10, 1'b1);
        repeat (9) cyc(1'b0, 1'b0, 3'd0);

        // Random stalls and branches.
        do_reset();
        load(3'd0, 8'h10, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(99) < 30, $urandom_range(99) < 20, 3'($urandom_range(7)));
        end

        // Second instance boots at 6 and must wrap to 0.
        do_reset();
        @(negedge clk);
        ifb.start_i = 1'b1;
        @(negedge clk);
        ifb.start_i = 1'b0;
        chk("b_first_v", 32'(ifb.inst_v_o), 32'd0);
        p = 3'd6;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b_v", 32'(ifb.inst_v_o), 32'd1);
            chk("b_pc", 32'(ifb.pc_o), 32'(p));
            chk("b_inst", 32'(ifb.inst_o), 32'(mem_m[p]));
            p = p + 3'd1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
